vx_cache_mem_beat_adapter: RTL and testbench

//  Sits directly downstream of the cache wrapper's memory port, one instance per MEM_PORT.

---
 rtl/vx_cache_mem_beat_adapter_if.sv | 57 +++++
 rtl/vx_cache_mem_beat_adapter.sv | 149 ++++++++++++++
 tb/tb_vx_cache_mem_beat_adapter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_cache_mem_beat_adapter_if.sv
// Bus bundle for the beat adapter: line-wide cache-side port plus beat-wide memory-side port.
// The adapter takes the slave modport; the cache/memory environment takes the master modport.
interface vx_cache_mem_beat_adapter_if #(
    parameter int LINE_SIZE     = 64,
    parameter int MEM_DATA_SIZE = 16,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_WIDTH     = 8
);
    localparam int RATIO      = LINE_SIZE / MEM_DATA_SIZE;
    localparam int MEM_ADDR_W = ADDR_WIDTH + $clog2(RATIO);

    logic                     core_req_valid;
    logic                     core_req_rw;
    logic [ADDR_WIDTH-1:0]    core_req_addr;
    logic [LINE_SIZE-1:0]     core_req_byteen;
    logic [LINE_SIZE*8-1:0]   core_req_data;
    logic [TAG_WIDTH-1:0]     core_req_tag;
    logic                     core_req_ready;

    logic                     core_rsp_valid;
    logic [LINE_SIZE*8-1:0]   core_rsp_data;
    logic [TAG_WIDTH-1:0]     core_rsp_tag;
    logic                     core_rsp_ready;

    logic                     mem_req_valid;
    logic                     mem_req_rw;
    logic [MEM_ADDR_W-1:0]    mem_req_addr;
    logic [MEM_DATA_SIZE-1:0] mem_req_byteen;
    logic [MEM_DATA_SIZE*8-1:0] mem_req_data;
    logic                     mem_req_ready;

    logic                     mem_rsp_valid;
    logic [MEM_DATA_SIZE*8-1:0] mem_rsp_data;
    logic                     mem_rsp_ready;

    modport master (
        output core_req_valid, core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag,
        input  core_req_ready,
        input  core_rsp_valid, core_rsp_data, core_rsp_tag,
        output core_rsp_ready,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  mem_rsp_ready
    );

    modport slave (
        input  core_req_valid, core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag,
        output core_req_ready,
        output core_rsp_valid, core_rsp_data, core_rsp_tag,
        input  core_rsp_ready,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output mem_rsp_ready
    );
endinterface

// File: rtl/vx_cache_mem_beat_adapter.sv
// Splits line-wide cache memory requests into RATIO beats and reassembles in-order read beats
// into lines, returning each line with the tag of the oldest pending read.
module vx_cache_mem_beat_adapter #(
    parameter int LINE_SIZE     = 64,
    parameter int MEM_DATA_SIZE = 16,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_PENDING   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    vx_cache_mem_beat_adapter_if.slave  bus
);
    localparam int RATIO     = LINE_SIZE / MEM_DATA_SIZE;
    localparam int LOG_RATIO = $clog2(RATIO);
    localparam int IDX_W     = (LOG_RATIO > 0) ? LOG_RATIO : 1;
    localparam int BEAT_W    = MEM_DATA_SIZE * 8;
    localparam int PTR_W     = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W     = $clog2(MAX_PENDING + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_PENDING - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         req_idx_q, req_idx_d;
    logic [IDX_W-1:0]         rsp_idx_q, rsp_idx_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         pend_cnt_q, pend_cnt_d;

    logic                     rw_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [LINE_SIZE-1:0]     byteen_q;
    logic [LINE_SIZE*8-1:0]   data_q;
    logic [LINE_SIZE*8-1:0]   line_q;
    logic [TAG_WIDTH-1:0]     tag_fifo_q [MAX_PENDING];

    logic                     req_ready, req_fire, push, rsp_beat_fire, rsp_pop;
    logic [BEAT_W-1:0]        beat_data;
    logic [MEM_DATA_SIZE-1:0] beat_byteen;

    assign req_fire      = bus.core_req_valid && req_ready;
    assign push          = req_fire && !bus.core_req_rw;
    assign rsp_beat_fire = bus.mem_rsp_valid && !rsp_valid_q;
    assign rsp_pop       = rsp_valid_q && bus.core_rsp_ready;

    // Request FSM: one line accepted in IDLE, then its beats issued in SEND.
    always_comb begin
        state_d   = state_q;
        req_idx_d = req_idx_q;
        req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !reset && (bus.core_req_rw || (pend_cnt_q < CNT_W'(MAX_PENDING)));
                if (bus.core_req_valid && req_ready) begin
                    state_d   = SEND;
                    req_idx_d = '0;
                end
            end
            SEND: begin
                if (bus.mem_req_ready) begin
                    req_idx_d = (req_idx_q == LAST_IDX) ? '0 : req_idx_q + 1'b1;
                    if (req_idx_q == LAST_IDX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response reassembly and tag FIFO bookkeeping.
    always_comb begin
        rsp_idx_d   = rsp_idx_q;
        rsp_valid_d = rsp_valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_cnt_d  = pend_cnt_q;
        if (rsp_beat_fire) begin
            rsp_idx_d = (rsp_idx_q == LAST_IDX) ? '0 : rsp_idx_q + 1'b1;
            if (rsp_idx_q == LAST_IDX) rsp_valid_d = 1'b1;
        end
        if (rsp_pop) begin
            rsp_valid_d = 1'b0;
            rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (push && !rsp_pop)      pend_cnt_d = pend_cnt_q + 1'b1;
        else if (!push && rsp_pop) pend_cnt_d = pend_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_idx_q   <= '0;
            rsp_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_idx_q   <= req_idx_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_valid_q <= rsp_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_cnt_q  <= pend_cnt_d;
        end
    end

    // Datapath storage carries no reset; control qualifies every use of it.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            rw_q     <= bus.core_req_rw;
            addr_q   <= bus.core_req_addr;
            byteen_q <= bus.core_req_byteen;
            data_q   <= bus.core_req_data;
        end
        if (push) tag_fifo_q[wr_ptr_q] <= bus.core_req_tag;
        if (rsp_beat_fire) line_q[BEAT_W*int'(rsp_idx_q) +: BEAT_W] <= bus.mem_rsp_data;
    end

    assign beat_data   = data_q[BEAT_W*int'(req_idx_q) +: BEAT_W];
    assign beat_byteen = byteen_q[MEM_DATA_SIZE*int'(req_idx_q) +: MEM_DATA_SIZE];

    assign bus.core_req_ready = req_ready;
    assign bus.mem_req_valid  = (state_q == SEND);
    assign bus.mem_req_rw     = rw_q;
    assign bus.mem_req_byteen = rw_q ? beat_byteen : '1;
    assign bus.mem_req_data   = rw_q ? beat_data : '0;

    generate
        if (RATIO == 1) begin : g_addr_single
            assign bus.mem_req_addr = addr_q;
        end else begin : g_addr_multi
            assign bus.mem_req_addr = {addr_q, req_idx_q};
        end
    endgenerate

    assign bus.mem_rsp_ready  = !rsp_valid_q;
    assign bus.core_rsp_valid = rsp_valid_q;
    assign bus.core_rsp_data  = line_q;
    assign bus.core_rsp_tag   = tag_fifo_q[rd_ptr_q];

    a_ratio_pow2: assert property (@(posedge clk)
        (RATIO >= 1) && ((RATIO & (RATIO - 1)) == 0) && ((LINE_SIZE % MEM_DATA_SIZE) == 0));
    a_rsp_needs_pending: assert property (@(posedge clk) disable iff (reset)
        bus.mem_rsp_valid |-> (pend_cnt_q != '0));
endmodule

// File: tb/tb_vx_cache_mem_beat_adapter.sv
// Directed bench for the cache line-to-beat adapter with LINE_SIZE 64, MEM_DATA_SIZE 16 (4 beats).
module tb_vx_cache_mem_beat_adapter;
    localparam int LS = 64, MDS = 16, AW = 26, TW = 8, MP = 4;
    localparam int R   = LS / MDS;
    localparam int MAW = AW + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    vx_cache_mem_beat_adapter_if #(.LINE_SIZE(LS), .MEM_DATA_SIZE(MDS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    vx_cache_mem_beat_adapter #(.LINE_SIZE(LS), .MEM_DATA_SIZE(MDS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                                .MAX_PENDING(MP)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [127:0] beat(input int k);
        return {16{8'(k)}};
    endfunction

    function automatic logic [511:0] line(input int b);
        return {beat(b + 3), beat(b + 2), beat(b + 1), beat(b)};
    endfunction

    task automatic drive_req(input logic rw, input logic [AW-1:0] a, input logic [63:0] be,
                             input logic [511:0] d, input logic [TW-1:0] t);
        bus.core_req_valid  = 1'b1;
        bus.core_req_rw     = rw;
        bus.core_req_addr   = a;
        bus.core_req_byteen = be;
        bus.core_req_data   = d;
        bus.core_req_tag    = t;
        #1;
    endtask

    task automatic end_req;
        @(posedge clk);
        @(negedge clk);
        bus.core_req_valid = 1'b0;
    endtask

    task automatic run_beats;
        repeat (R) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic deliver_line(input int b);
        for (int i = 0; i < R; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beat(b + i);
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        #1;
    endtask

    task automatic pop;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.core_req_valid = 1'b1;
        bus.core_req_rw    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_tests++; if (bus.core_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %0h want 0", bus.core_req_ready); end
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid: got %0h want 0", bus.mem_req_valid); end
        n_tests++; if (bus.core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_core_rsp_valid: got %0h want 0", bus.core_rsp_valid); end
        n_tests++; if (bus.mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mem_rsp_ready: got %0h want 1", bus.mem_rsp_ready); end
        bus.core_req_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0h want 1", bus.core_req_ready); end
    endtask

    task automatic test_read;
        drive_req(1'b0, 26'h10, '0, '0, 8'h5A);
        n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_req_ready: got %0h want 1", bus.core_req_ready); end
        end_req;
        for (int i = 0; i < R; i++) begin
            #1;
            n_tests++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rd_beat_valid%0d: got %0h want 1", i, bus.mem_req_valid); end
            n_tests++; if (bus.mem_req_addr !== 28'h40 + 28'(i)) begin n_fail++; $display("FAIL rd_beat_addr%0d: got %h want %h", i, bus.mem_req_addr, 28'h40 + 28'(i)); end
            n_tests++; if (bus.mem_req_byteen !== 16'hFFFF || bus.mem_req_data !== 128'h0 || bus.mem_req_rw !== 1'b0) begin
                n_fail++; $display("FAIL rd_beat_be%0d: got be %h data %h rw %0h want be ffff data 0 rw 0", i, bus.mem_req_byteen, bus.mem_req_data, bus.mem_req_rw); end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_beats_done: got %0h want 0", bus.mem_req_valid); end
        deliver_line(8'hC0);
        n_tests++; if (bus.core_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %0h want 1", bus.core_rsp_valid); end
        n_tests++; if (bus.core_rsp_tag !== 8'h5A) begin n_fail++; $display("FAIL rd_rsp_tag: got %h want 5a", bus.core_rsp_tag); end
        n_tests++; if (bus.core_rsp_data !== line(8'hC0)) begin n_fail++; $display("FAIL rd_rsp_data: got %h want %h", bus.core_rsp_data, line(8'hC0)); end
        n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_hold: got %0h want 0", bus.mem_rsp_ready); end
        pop;
        n_tests++; if (bus.core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_pop: got %0h want 0", bus.core_rsp_valid); end
    endtask

    task automatic test_write;
        drive_req(1'b1, 26'h21, 64'hFFFF, line(8'h60), 8'hEE);
        n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_req_ready: got %0h want 1", bus.core_req_ready); end
        end_req;
        for (int i = 0; i < R; i++) begin
            #1;
            n_tests++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_rw !== 1'b1 || bus.mem_req_addr !== 28'h84 + 28'(i)) begin
                n_fail++; $display("FAIL wr_beat_addr%0d: got v %0h rw %0h addr %h want v 1 rw 1 addr %h", i, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr, 28'h84 + 28'(i)); end
            n_tests++; if (bus.mem_req_byteen !== ((i == 0) ? 16'hFFFF : 16'h0)) begin
                n_fail++; $display("FAIL wr_beat_be%0d: got %h want %h", i, bus.mem_req_byteen, (i == 0) ? 16'hFFFF : 16'h0); end
            n_tests++; if (bus.mem_req_data !== beat(8'h60 + i)) begin n_fail++; $display("FAIL wr_beat_data%0d: got %h want %h", i, bus.mem_req_data, beat(8'h60 + i)); end
            @(posedge clk);
            @(negedge clk);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_tests++; if (bus.core_rsp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_no_rsp: got rsp %0h memv %0h want 0 0", bus.core_rsp_valid, bus.mem_req_valid); end
    endtask

    task automatic test_stall;
        logic [9:0] pat;
        int hs, idx;
        pat = 10'b1111111001;
        hs  = 0;
        idx = 0;
        drive_req(1'b1, 26'h33, '1, line(8'h80), 8'h00);
        end_req;
        for (int c = 0; c < 10; c++) begin
            bus.mem_req_ready = pat[c];
            #1;
            n_tests++; if (bus.mem_req_valid !== (c < 6)) begin n_fail++; $display("FAIL st_valid_c%0d: got %0h want %0h", c, bus.mem_req_valid, c < 6); end
            if (bus.mem_req_valid === 1'b1) begin
                n_tests++; if (bus.mem_req_addr !== 28'hCC + 28'(idx) || bus.mem_req_data !== beat(8'h80 + idx)) begin
                    n_fail++; $display("FAIL st_hold_c%0d: got addr %h data %h want addr %h data %h", c, bus.mem_req_addr, bus.mem_req_data, 28'hCC + 28'(idx), beat(8'h80 + idx)); end
                if (pat[c]) begin hs++; idx++; end
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b1;
        n_tests++; if (hs !== R) begin n_fail++; $display("FAIL st_handshakes: got %0d want %0d", hs, R); end
    endtask

    task automatic test_full;
        for (int i = 0; i < MP; i++) begin
            drive_req(1'b0, 26'h100 + 26'(i), '0, '0, 8'(i + 1));
            n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %0h want 1", i, bus.core_req_ready); end
            end_req;
            run_beats;
        end
        drive_req(1'b0, 26'h104, '0, '0, 8'h15);
        n_tests++; if (bus.core_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_rd_stall: got %0h want 0", bus.core_req_ready); end
        @(posedge clk); @(negedge clk); #1;
        n_tests++; if (bus.core_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_rd_stall2: got %0h want 0", bus.core_req_ready); end
        drive_req(1'b1, 26'h200, '1, line(8'hA0), 8'h00);
        n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_wr_ok: got %0h want 1", bus.core_req_ready); end
        end_req;
        run_beats;
        deliver_line(8'h10);
        n_tests++; if (bus.core_rsp_valid !== 1'b1 || bus.core_rsp_tag !== 8'h01 || bus.core_rsp_data !== line(8'h10)) begin
            n_fail++; $display("FAIL full_rsp1: got v %0h tag %h data %h want v 1 tag 01 data %h", bus.core_rsp_valid, bus.core_rsp_tag, bus.core_rsp_data, line(8'h10)); end
        drive_req(1'b0, 26'h104, '0, '0, 8'h15);
        n_tests++; if (bus.core_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_before_pop: got %0h want 0", bus.core_req_ready); end
        pop;
        n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got %0h want 1", bus.core_req_ready); end
        end_req;
        run_beats;
    endtask

    task automatic test_backpressure;
        bus.core_rsp_ready = 1'b0;
        deliver_line(8'h20);
        n_tests++; if (bus.core_rsp_valid !== 1'b1 || bus.core_rsp_tag !== 8'h02) begin
            n_fail++; $display("FAIL bp_rsp2: got v %0h tag %h want v 1 tag 02", bus.core_rsp_valid, bus.core_rsp_tag); end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = beat(8'h30);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk); #1;
            n_tests++; if (bus.mem_rsp_ready !== 1'b0 || bus.core_rsp_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold_c%0d: got mrdy %0h rspv %0h want 0 1", c, bus.mem_rsp_ready, bus.core_rsp_valid); end
        end
        bus.core_rsp_ready = 1'b1;
        pop;
        n_tests++; if (bus.core_rsp_valid !== 1'b0 || bus.mem_rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got rspv %0h mrdy %0h want 0 1", bus.core_rsp_valid, bus.mem_rsp_ready); end
        deliver_line(8'h30);
        n_tests++; if (bus.core_rsp_tag !== 8'h03 || bus.core_rsp_data !== line(8'h30)) begin
            n_fail++; $display("FAIL bp_rsp3: got tag %h data %h want tag 03 data %h", bus.core_rsp_tag, bus.core_rsp_data, line(8'h30)); end
        pop;
        deliver_line(8'h40);
        n_tests++; if (bus.core_rsp_tag !== 8'h04 || bus.core_rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_rsp4: got v %0h tag %h want v 1 tag 04", bus.core_rsp_valid, bus.core_rsp_tag); end
        pop;
        deliver_line(8'h50);
        n_tests++; if (bus.core_rsp_tag !== 8'h15 || bus.core_rsp_data !== line(8'h50)) begin
            n_fail++; $display("FAIL bp_rsp5: got tag %h data %h want tag 15 data %h", bus.core_rsp_tag, bus.core_rsp_data, line(8'h50)); end
        pop;
    endtask

    task automatic test_reset_mid;
        drive_req(1'b0, 26'h2A, '0, '0, 8'h3C);
        end_req;
        run_beats;
        for (int i = 0; i < 2; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beat(8'hE0 + i);
            @(posedge clk); @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        reset = 1'b1;
        drive_req(1'b1, 26'h2B, '1, '0, 8'h00);
        n_tests++; if (bus.core_req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_reset: got %0h want 0", bus.core_req_ready); end
        @(posedge clk); @(negedge clk); #1;
        n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.core_rsp_valid !== 1'b0 || bus.core_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL rm_valids: got memv %0h rspv %0h rdy %0h want 0 0 0", bus.mem_req_valid, bus.core_rsp_valid, bus.core_req_ready); end
        bus.core_req_valid = 1'b0;
        reset = 1'b0;
        drive_req(1'b0, 26'h2B, '0, '0, 8'h44);
        n_tests++; if (bus.core_req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_new_ready: got %0h want 1", bus.core_req_ready); end
        end_req;
        #1;
        n_tests++; if (bus.mem_req_addr !== 28'hAC || bus.mem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_new_addr: got v %0h addr %h want v 1 addr 0ac", bus.mem_req_valid, bus.mem_req_addr); end
        run_beats;
        deliver_line(8'hF0);
        n_tests++; if (bus.core_rsp_valid !== 1'b1 || bus.core_rsp_tag !== 8'h44 || bus.core_rsp_data !== line(8'hF0)) begin
            n_fail++; $display("FAIL rm_new_rsp: got v %0h tag %h data %h want v 1 tag 44 data %h", bus.core_rsp_valid, bus.core_rsp_tag, bus.core_rsp_data, line(8'hF0)); end
        pop;
        n_tests++; if (bus.core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_pop: got %0h want 0", bus.core_rsp_valid); end
    endtask

    initial begin
        bus.core_req_valid  = 1'b0;
        bus.core_req_rw     = 1'b0;
        bus.core_req_addr   = '0;
        bus.core_req_byteen = '0;
        bus.core_req_data   = '0;
        bus.core_req_tag    = '0;
        bus.core_rsp_ready  = 1'b1;
        bus.mem_req_ready   = 1'b1;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = '0;
        @(negedge clk);
        test_reset;
        test_read;
        test_write;
        test_stall;
        test_full;
        test_backpressure;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
